pkt_tx_scheduler: RTL and testbench

//  Transmit-side scheduler for the pixel packet link. Shares the DIN stream
//  of the downstream packet picker among NUM_REQ pixel sources: round-robin

---
 rtl/pkt_tx_scheduler.sv | 160 ++++++++++++++++
 tb/tb_pkt_tx_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pkt_tx_scheduler.sv
// Round-robin scheduler and packet framer feeding the pixel packet picker DIN.
// Define PKT_TX_CHKSUM_EN to append an XOR checksum word after the pixel data.
module pkt_tx_scheduler #(
    parameter int pixelWidth = 16,
    parameter int NUM_REQ    = 4,
    parameter int NUM_PIXEL  = 16
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ*pixelWidth-1:0] PIX_IN,
    output logic [NUM_REQ-1:0]            GNT,
    output logic [NUM_REQ-1:0]            PIX_RD,
    output logic [pixelWidth-1:0]         DOUT,
    output logic                          DOUT_VALID,
    output logic                          BUSY
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (NUM_PIXEL > 1) ? $clog2(NUM_PIXEL) : 1;
    localparam logic [pixelWidth-1:0] WORD_HDR  = pixelWidth'(16'hFFFF);
    localparam logic [pixelWidth-1:0] WORD_SYNC = pixelWidth'(16'hAAAA);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_SYNC = 3'd3,
        ST_CNTL = 3'd4,
        ST_DATA = 3'd5,
`ifdef PKT_TX_CHKSUM_EN
        ST_CHK  = 3'd6,
`endif
        ST_GAP  = 3'd7
    } state_t;

    state_t                state_r, next_state_s;
    logic [IW-1:0]         gid_r, last_r, win_id_s, scan_s;
    logic                  win_found_s, hit_s;
    logic [7:0]            seq_r [NUM_REQ];
    logic [CW-1:0]         beat_r;
    logic                  last_beat_s;
    logic [NUM_REQ-1:0]    gnt_oh_s;
    logic [pixelWidth-1:0] pix_sel_s, cntl_s;
`ifdef PKT_TX_CHKSUM_EN
    logic [pixelWidth-1:0] chk_r;
`endif

    assign gnt_oh_s    = NUM_REQ'(1) << gid_r;
    assign pix_sel_s   = PIX_IN[int'(gid_r)*pixelWidth +: pixelWidth];
    assign cntl_s      = {(pixelWidth-8)'(gid_r), seq_r[gid_r]};
    assign last_beat_s = (beat_r == CW'(NUM_PIXEL - 1));

    // Round-robin search starting just after the previous winner
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = last_r;
        scan_s      = last_r;
        hit_s       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_s      = (scan_s == IW'(NUM_REQ - 1)) ? IW'(0) : scan_s + IW'(1);
            hit_s       = ~win_found_s & REQ[scan_s];
            win_id_s    = hit_s ? scan_s : win_id_s;
            win_found_s = win_found_s | hit_s;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        next_state_s = state_r;
        GNT          = '0;
        PIX_RD       = '0;
        DOUT         = '0;
        DOUT_VALID   = 1'b0;
        BUSY         = 1'b1;
        case (state_r)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (win_found_s) next_state_s = ST_HDR0;
                else             next_state_s = ST_IDLE;
            end
            ST_HDR0: begin
                next_state_s = ST_HDR1;
                GNT          = gnt_oh_s;
                DOUT         = WORD_HDR;
                DOUT_VALID   = 1'b1;
            end
            ST_HDR1: begin
                next_state_s = ST_SYNC;
                GNT          = gnt_oh_s;
                DOUT         = WORD_HDR;
                DOUT_VALID   = 1'b1;
            end
            ST_SYNC: begin
                next_state_s = ST_CNTL;
                GNT          = gnt_oh_s;
                DOUT         = WORD_SYNC;
                DOUT_VALID   = 1'b1;
            end
            ST_CNTL: begin
                next_state_s = ST_DATA;
                GNT          = gnt_oh_s;
                DOUT         = cntl_s;
                DOUT_VALID   = 1'b1;
            end
            ST_DATA: begin
                GNT        = gnt_oh_s;
                PIX_RD     = gnt_oh_s;
                DOUT       = pix_sel_s;
                DOUT_VALID = 1'b1;
`ifdef PKT_TX_CHKSUM_EN
                if (last_beat_s) next_state_s = ST_CHK;
`else
                if (last_beat_s) next_state_s = ST_GAP;
`endif
                else             next_state_s = ST_DATA;
            end
`ifdef PKT_TX_CHKSUM_EN
            ST_CHK: begin
                next_state_s = ST_GAP;
                GNT          = gnt_oh_s;
                DOUT         = chk_r;
                DOUT_VALID   = 1'b1;
            end
`endif
            ST_GAP: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, grant bookkeeping, beat counter and per-source sequence numbers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
            gid_r   <= '0;
            last_r  <= IW'(NUM_REQ - 1);
            beat_r  <= '0;
            for (int i = 0; i < NUM_REQ; i++) seq_r[i] <= 8'd0;
`ifdef PKT_TX_CHKSUM_EN
            chk_r   <= '0;
`endif
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_IDLE && win_found_s) begin
                gid_r  <= win_id_s;
                last_r <= win_id_s;
            end
            beat_r <= (state_r == ST_DATA) ? beat_r + CW'(1) : CW'(0);
            if (state_r == ST_GAP) seq_r[gid_r] <= seq_r[gid_r] + 8'd1;
`ifdef PKT_TX_CHKSUM_EN
            if (state_r == ST_CNTL)      chk_r <= '0;
            else if (state_r == ST_DATA) chk_r <= chk_r ^ pix_sel_s;
`endif
        end
    end

endmodule

// File: tb/tb_pkt_tx_scheduler.sv
// Self-checking bench for pkt_tx_scheduler: packet vector table plus scoreboard
// of expected link words, with hand-written reset and sequence-wrap sequences.
module tb_pkt_tx_scheduler;
    localparam int PW = 16;
    localparam int NR = 4;
    localparam int NP = 16;
`ifdef PKT_TX_CHKSUM_EN
    localparam int PKT_BUSY = NP + 6;
`else
    localparam int PKT_BUSY = NP + 5;
`endif
    localparam logic [15:0] SRC_BASE [NR] = '{16'hFFF8, 16'hAAA0, 16'h0100, 16'h3000};

    typedef struct {
        logic [15:0] dout;
        logic [3:0]  gnt;
        logic [3:0]  rd;
    } word_t;

    typedef struct {
        logic [3:0] req;
        int         gid;
    } vec_t;

    logic        CLK;
    logic        nRST;
    logic [3:0]  REQ;
    logic [63:0] PIX_IN;
    logic [3:0]  GNT;
    logic [3:0]  PIX_RD;
    logic [15:0] DOUT;
    logic        DOUT_VALID;
    logic        BUSY;

    int         n_chk = 0;
    int         n_fail = 0;
    word_t      sb_q[$];
    int         src_cnt [NR] = '{0, 0, 0, 0};
    int         exp_cnt [NR] = '{0, 0, 0, 0};
    logic [7:0] seq_m [NR] = '{8'h00, 8'h00, 8'h00, 8'h00};

    pkt_tx_scheduler #(.pixelWidth(PW), .NUM_REQ(NR), .NUM_PIXEL(NP)) dut (
        .CLK(CLK), .nRST(nRST), .REQ(REQ), .PIX_IN(PIX_IN), .GNT(GNT),
        .PIX_RD(PIX_RD), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .BUSY(BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // FWFT source model: each pop advances that source's word
    always_comb begin
        PIX_IN = '0;
        for (int i = 0; i < NR; i++) PIX_IN[i*PW +: PW] = SRC_BASE[i] + 16'(src_cnt[i]);
    end

    always @(posedge CLK) begin
        for (int i = 0; i < NR; i++) begin
            if (PIX_RD[i]) src_cnt[i] <= src_cnt[i] + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int gid, input int nbeats, input bit full);
        word_t       w;
        logic [15:0] x;
        logic [3:0]  oh;
        oh     = 4'b0001 << gid;
        x      = 16'h0000;
        w.gnt  = oh;
        w.rd   = 4'b0000;
        w.dout = 16'hFFFF;
        sb_q.push_back(w);
        sb_q.push_back(w);
        w.dout = 16'hAAAA;
        sb_q.push_back(w);
        w.dout = {8'(gid), seq_m[gid]};
        sb_q.push_back(w);
        w.rd = oh;
        for (int n = 0; n < nbeats; n++) begin
            w.dout = SRC_BASE[gid] + 16'(exp_cnt[gid] + n);
            x      = x ^ w.dout;
            sb_q.push_back(w);
        end
        if (full) begin
`ifdef PKT_TX_CHKSUM_EN
            w.rd   = 4'b0000;
            w.dout = x;
            sb_q.push_back(w);
`endif
            exp_cnt[gid] += NP;
            seq_m[gid]   += 8'd1;
        end
    endtask

    // Called at a negedge while the DUT idles; returns at the next idle negedge
    task automatic run_pkt(input logic [3:0] req, input int gid);
        int cyc;
        int rd;
        push_frame(gid, NP, 1'b1);
        REQ = req;
        @(negedge CLK);
        chk("busy_start", 32'(BUSY), 32'd1);
        cyc = 0;
        rd  = 0;
        while (BUSY === 1'b1 && cyc < 60) begin
            rd  += $countones(PIX_RD);
            cyc++;
            @(negedge CLK);
        end
        chk("busy_len", 32'(cyc), 32'(PKT_BUSY));
        chk("pix_rd_count", 32'(rd), 32'(NP));
    endtask

    // Scoreboard monitor
    initial begin
        word_t e;
        forever begin
            @(negedge CLK);
            chk("gnt_onehot0", 32'($onehot0(GNT)), 32'd1);
            chk("rd_in_gnt", 32'(PIX_RD & ~GNT), 32'd0);
            if (DOUT_VALID === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no valid word at %0t", DOUT, $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("dout", 32'(DOUT), 32'(e.dout));
                    chk("gnt", 32'(GNT), 32'(e.gnt));
                    chk("pix_rd", 32'(PIX_RD), 32'(e.rd));
                    chk("busy_valid", 32'(BUSY), 32'd1);
                end
            end else begin
                chk("idle_dout", 32'(DOUT), 32'd0);
                chk("idle_gnt", 32'(GNT), 32'd0);
                chk("idle_rd", 32'(PIX_RD), 32'd0);
            end
        end
    end

    initial begin
        vec_t vt [10];
        vt = '{'{4'b1111, 0}, '{4'b1111, 1}, '{4'b1111, 2}, '{4'b1111, 3}, '{4'b1111, 0},
               '{4'b0100, 2}, '{4'b1010, 3}, '{4'b1010, 1}, '{4'b0011, 0}, '{4'b0001, 0}};

        nRST = 1'b0;
        REQ  = 4'b1111;
        repeat (3) @(negedge CLK);
        chk("rst_dout", 32'(DOUT), 32'd0);
        chk("rst_valid", 32'(DOUT_VALID), 32'd0);
        chk("rst_gnt", 32'(GNT), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_rd", 32'(PIX_RD), 32'd0);
        REQ  = 4'b0000;
        nRST = 1'b1;
        @(negedge CLK);
        chk("idle_busy", 32'(BUSY), 32'd0);

        for (int t = 0; t < 10; t++) run_pkt(vt[t].req, vt[t].gid);

        // Sequence number wrap on src1
        for (int p = 0; p < 256; p++) run_pkt(4'b0010, 1);
        REQ = 4'b0000;
        repeat (3) @(negedge CLK);
        chk("wrap_seq_model", 32'(seq_m[1]), 32'd2);

        // Reset asserted during DATA beat 7 truncates the packet at once
        push_frame(0, 8, 1'b0);
        REQ = 4'b0001;
        @(negedge CLK);
        repeat (11) @(negedge CLK);
        #2;
        nRST = 1'b0;
        REQ  = 4'b0000;
        #1;
        chk("trunc_dout", 32'(DOUT), 32'd0);
        chk("trunc_valid", 32'(DOUT_VALID), 32'd0);
        chk("trunc_gnt", 32'(GNT), 32'd0);
        chk("trunc_rd", 32'(PIX_RD), 32'd0);
        chk("trunc_busy", 32'(BUSY), 32'd0);
        chk("trunc_sb", 32'(sb_q.size()), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < NR; i++) seq_m[i] = 8'h00;
        run_pkt(4'b1000, 3);
        REQ = 4'b0000;
        repeat (3) @(negedge CLK);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
